ov7670_config_sequencer: RTL and testbench

Walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry {register, value} into one SCCB register write. It sits between the config ROM (upstream) and the SCCB master (downstream), and is started once after power-up or on request. Entry 16'hFFF0 inserts a fixed settle delay (used after the soft reset). Entry 16'hFFFF ends the sequence and raises `done`.

---
 rtl/ov7670_config_sequencer.sv | 111 +++++++++++
 tb/tb_ov7670_config_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks the config ROM and issues one SCCB
// register write per entry, with 16'hFFF0 as a settle delay and 16'hFFFF as end marker.
module ov7670_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_data,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT_ACK,
    WAIT_DONE,
    DELAY,
    DONE
  } state_t;

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
  localparam logic [23:0] DELAY_LOAD  = 24'(DELAY_CYCLES - 1);

  state_t      state;
  logic [23:0] cnt;
  logic        last_addr;

  assign last_addr = (rom_addr == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= '0;
      sccb_data  <= '0;
      done       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end

        FETCH: state <= DECODE;

        DECODE: begin
          if (rom_dout == ENTRY_END) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (rom_dout == ENTRY_DELAY) begin
            cnt   <= DELAY_LOAD;
            state <= DELAY;
          end else if (sccb_ready) begin
            sccb_reg   <= rom_dout[15:8];
            sccb_data  <= rom_dout[7:0];
            sccb_start <= 1'b1;
            state      <= WAIT_ACK;
          end
        end

        // Ready is ignored here: the master may still show idle the cycle it samples start.
        WAIT_ACK: begin
          sccb_start <= 1'b0;
          state      <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (sccb_ready) begin
            if (last_addr) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end
        end

        DELAY: begin
          if (cnt == '0) begin
            if (last_addr) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer with a registered ROM model and a
// simple SCCB master model that stays busy for a fixed time after each write.
module tb_ov7670_config_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = '0;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        done;

  logic [15:0] rom [256];
  logic        mready = 1'b1;
  logic        hold_low = 1'b0;
  int unsigned busy = 0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Monitor state (written only by the monitor process).
  logic [15:0] wr_q[$];
  logic        prev_start = 1'b0;
  int unsigned width_err = 0;
  int unsigned a1_cnt = 0;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(.DELAY_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .sccb_ready (sccb_ready),
    .sccb_start (sccb_start),
    .sccb_reg   (sccb_reg),
    .sccb_data  (sccb_data),
    .done       (done)
  );

  always @(posedge clk) rom_dout <= rom[rom_addr];

  assign sccb_ready = mready & ~hold_low;

  always @(posedge clk) begin
    if (sccb_start) begin
      busy   <= 20;
      mready <= 1'b0;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) mready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sccb_start) begin
      if (prev_start) width_err = width_err + 1;
      else wr_q.push_back({sccb_reg, sccb_data});
    end
    prev_start = sccb_start;
    if (rom_addr == 8'd1 && !done) a1_cnt = a1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [7:0] a, input int unsigned limit);
    int unsigned i;
    i = 0;
    while (rom_addr != a && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (rom_addr != a) check({tag, "_timeout"}, {24'd0, rom_addr}, {24'd0, a});
  endtask

  task automatic load_short_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
    rom[3] = 16'hFFFF;
  endtask

  initial begin
    int unsigned base;
    int unsigned a1_base;
    int unsigned bad;

    load_short_rom();

    // Reset state and idling with start low
    repeat (3) @(negedge clk);
    check("rst_addr", {24'd0, rom_addr}, 32'd0);
    check("rst_start", {31'd0, sccb_start}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    base = wr_q.size();
    repeat (10) @(negedge clk);
    check("idle_no_write", wr_q.size() - base, 32'd0);
    check("idle_addr", {24'd0, rom_addr}, 32'd0);

    // Short ROM run
    base = wr_q.size();
    a1_base = a1_cnt;
    pulse_start();
    wait_done("short", 500);
    check("short_nwr", wr_q.size() - base, 32'd2);
    if (wr_q.size() >= base + 2) begin
      check("short_wr0", {16'd0, wr_q[base]}, 32'h1280);
      check("short_wr1", {16'd0, wr_q[base+1]}, 32'h1204);
    end
    // addr 1 spans FETCH + DECODE + 8 DELAY cycles
    check("short_delay_len", a1_cnt - a1_base, 32'd10);
    check("short_done", {31'd0, done}, 32'd1);
    check("short_addr", {24'd0, rom_addr}, 32'd3);
    check("short_width", width_err, 32'd0);

    // Replay from DONE, with a start pulse mid-sequence that must be ignored
    base = wr_q.size();
    a1_base = a1_cnt;
    pulse_start();
    check("replay_done_low", {31'd0, done}, 32'd0);
    check("replay_addr0", {24'd0, rom_addr}, 32'd0);
    wait_addr("replay_a1", 8'd1, 200);
    pulse_start();
    check("mid_start_addr", {24'd0, rom_addr}, 32'd1);
    wait_done("replay", 500);
    check("replay_nwr", wr_q.size() - base, 32'd2);
    if (wr_q.size() >= base + 2) begin
      check("replay_wr0", {16'd0, wr_q[base]}, 32'h1280);
      check("replay_wr1", {16'd0, wr_q[base+1]}, 32'h1204);
    end
    check("replay_delay_len", a1_cnt - a1_base, 32'd10);
    check("replay_addr", {24'd0, rom_addr}, 32'd3);

    // Ready backpressure, plus register FF with non-F0 data as an ordinary write
    rom[0] = 16'h3A04;
    rom[1] = 16'hFF00;
    rom[2] = 16'hFFFF;
    hold_low = 1'b1;
    base = wr_q.size();
    pulse_start();
    repeat (50) @(negedge clk);
    check("bp_no_write", wr_q.size() - base, 32'd0);
    check("bp_start_low", {31'd0, sccb_start}, 32'd0);
    hold_low = 1'b0;
    wait_done("bp", 500);
    check("bp_nwr", wr_q.size() - base, 32'd2);
    if (wr_q.size() >= base + 2) begin
      check("bp_wr0", {16'd0, wr_q[base]}, 32'h3A04);
      check("bp_wr_ff00", {16'd0, wr_q[base+1]}, 32'hFF00);
    end
    check("bp_width", width_err, 32'd0);

    // Asynchronous reset during DELAY (counter at 3)
    load_short_rom();
    pulse_start();
    wait_addr("rd_a1", 8'd1, 200);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rd_addr", {24'd0, rom_addr}, 32'd0);
    check("rd_reg", {24'd0, sccb_reg}, 32'd0);
    check("rd_data", {24'd0, sccb_data}, 32'd0);
    check("rd_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_q.size();
    pulse_start();
    wait_done("rd", 500);
    check("rd_nwr", wr_q.size() - base, 32'd2);
    if (wr_q.size() >= base + 1) check("rd_wr0", {16'd0, wr_q[base]}, 32'h1280);

    // Asynchronous reset while sccb_start is high
    pulse_start();
    begin
      int unsigned i;
      i = 0;
      while (!sccb_start && i < 50) begin
        @(negedge clk);
        i++;
      end
    end
    check("rs_start_seen", {31'd0, sccb_start}, 32'd1);
    rst = 1'b1;
    #1;
    check("rs_start_drop", {31'd0, sccb_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Unterminated ROM: 256 writes then done at address 255
    for (int i = 0; i < 256; i++) rom[i] = 16'h0A55;
    base = wr_q.size();
    pulse_start();
    wait_done("unterm", 10000);
    check("unterm_nwr", wr_q.size() - base, 32'd256);
    bad = 0;
    for (int i = base; i < wr_q.size(); i++) if (wr_q[i] != 16'h0A55) bad++;
    check("unterm_values", bad, 32'd0);
    check("unterm_addr", {24'd0, rom_addr}, 32'd255);
    check("unterm_done", {31'd0, done}, 32'd1);
    repeat (30) @(negedge clk);
    check("unterm_no_wrap", wr_q.size() - base, 32'd256);
    check("final_width", width_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
